// File: rtl/hash_packer.sv
// hash_packer: packs up to 8 message bytes into a 64-bit word for the
// combinational hasher, captures the hash, and presents result/len/trunc
// on a valid/ready output handshake. Bytes beyond the 8th are drained.
module hash_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] data,
  output logic [3:0]  data_len,
  input  logic [31:0] hash_in,
  output logic [31:0] out_hash,
  output logic [3:0]  out_len,
  output logic        out_trunc,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_HASH    = 2'd1,
    S_OUT     = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t state, state_next;
  logic   trunc;
  logic   accept;

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_COLLECT;
    else       state <= state_next;
  end

  // Next-state and handshake outputs, decoded from the current state only
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      S_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || data_len == 4'd7)) state_next = S_HASH;
      end
      S_HASH: begin
        state_next = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = trunc ? S_DRAIN : S_COLLECT;
      end
      S_DRAIN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_next = S_COLLECT;
      end
      default: state_next = S_COLLECT;
    endcase
  end

  // Packing datapath, truncation tracking and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data      <= '0;
      data_len  <= '0;
      trunc     <= 1'b0;
      out_hash  <= '0;
      out_len   <= '0;
      out_trunc <= 1'b0;
    end else begin
      unique case (state)
        S_COLLECT: begin
          if (accept) begin
            // data_len is 0..7 while collecting, so its low 3 bits pick the lane
            data[{data_len[2:0], 3'b000} +: 8] <= in_byte;
            data_len <= data_len + 4'd1;
            if (data_len == 4'd7 && !in_last) trunc <= 1'b1;
          end
        end
        S_HASH: begin
          out_hash  <= hash_in;
          out_len   <= data_len;
          out_trunc <= trunc;
        end
        S_OUT: begin
          if (out_ready) begin
            data     <= '0;
            data_len <= '0;
          end
        end
        S_DRAIN: begin
          if (accept && in_last) trunc <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
